// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU
// between two requesters; issue reg -> ALU -> tagged response reg.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic              id;
    } issue_t;

    issue_t issue;
    issue_t pick;
    logic   issue_valid;
    logic   rr_ptr;
    logic   grant;
    logic   stall;
    logic   issue_adv;
    logic   can_accept;
    logic   accept;

    assign stall      = rsp_valid & ~rsp_ready;
    assign issue_adv  = issue_valid & ~stall;
    assign can_accept = ~issue_valid | ~stall;
    assign accept     = can_accept & ~rst & (req0_valid | req1_valid);

    always_comb begin
        grant = 1'b0;
        unique case ({req1_valid, req0_valid})
            2'b11:   grant = rr_ptr;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    assign req0_ready = can_accept & ~rst & (grant == 1'b0);
    assign req1_ready = can_accept & ~rst & (grant == 1'b1);

    always_comb begin
        pick = '0;
        if (grant)
            pick = '{a: req1_a, b: req1_b, op: req1_op, tag: req1_tag, id: 1'b1};
        else
            pick = '{a: req0_a, b: req0_b, op: req0_op, tag: req0_tag, id: 1'b0};
    end

    assign alu_a  = issue.a;
    assign alu_b  = issue.b;
    assign alu_op = issue.op;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue       <= '0;
            issue_valid <= 1'b0;
            rr_ptr      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_id      <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            if (accept) begin
                issue  <= pick;
                rr_ptr <= ~grant;
            end
            // a new accept refills the slot even while it drains
            if (accept)
                issue_valid <= 1'b1;
            else if (issue_adv)
                issue_valid <= 1'b0;
            if (issue_adv) begin
                rsp_result <= alu_result;
                rsp_id     <= issue.id;
                rsp_tag    <= issue.tag;
                rsp_valid  <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed tests of the shared-ALU arbiter with a
// behavioural ALU attached to its alu_* ports.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_op, req0_tag;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_op, req1_tag;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_id;
    logic [3:0]  rsp_tag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic [3:0]  tag;
    } exp_t;

    always #5 clk = ~clk;

    // 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = alu_a << alu_b[4:0];
            4'd6: alu_result = alu_a >> alu_b[4:0];
            4'd7: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
            4'd9: alu_result = {31'h0, alu_a < alu_b};
            default: alu_result = 32'h0;
        endcase
    end

    alu_share_arbiter #(.DATA_W(32), .OP_W(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_tag = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_tag = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        rsp_ready = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        rsp_ready = 1;
        tick();
        req0_valid = 1;
        req1_valid = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 68'h0) begin
            errors++; $display("FAIL reset_alu got %h/%h/%h exp 0", alu_a, alu_b, alu_op);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp_result, rsp_id, rsp_tag} !== 37'h0) begin
            errors++; $display("FAIL reset_rsp got %h %b %h exp 0", rsp_result, rsp_id, rsp_tag);
        end
        idle_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_single;
        do_reset();
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 4'd1; req0_tag = 4'd7;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 32'd5) begin
            errors++; $display("FAIL single_issue got v=%b a=%h exp v=0 a=5", rsp_valid, alu_a);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd2 || rsp_id !== 1'b0 || rsp_tag !== 4'd7) begin
            errors++;
            $display("FAIL single_rsp got v=%b r=%h id=%b t=%h exp 1 2 0 7",
                     rsp_valid, rsp_result, rsp_id, rsp_tag);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        exp_t q[$];
        exp_t e;
        int   i0, i1;
        logic g;
        do_reset();
        i0 = 0; i1 = 0; g = 0;
        for (int c = 0; c < 8; c++) begin
            req0_valid = 1; req0_a = 32'(i0); req0_b = 10; req0_op = 4'd0; req0_tag = 4'(i0);
            req1_valid = 1; req1_a = 100; req1_b = 32'(i1); req1_op = 4'd1; req1_tag = 4'(8 + i1);
            #1;
            checks++;
            if (req0_ready !== (g == 1'b0) || req1_ready !== (g == 1'b1)) begin
                errors++;
                $display("FAIL rr_grant c=%0d got %b%b exp grant %b", c, req0_ready, req1_ready, g);
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1) begin
                    errors++; $display("FAIL rr_rate c=%0d got %b exp 1", c, rsp_valid);
                end
            end
            if (rsp_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({rsp_id, rsp_result, rsp_tag} !== e) begin
                    errors++;
                    $display("FAIL rr_rsp c=%0d got %b %h %h exp %b %h %h",
                             c, rsp_id, rsp_result, rsp_tag, e.id, e.res, e.tag);
                end
            end
            if (g == 1'b0) begin
                e.id = 0; e.res = 32'(i0 + 10); e.tag = 4'(i0); i0++;
            end else begin
                e.id = 1; e.res = 32'(100 - i1); e.tag = 4'(8 + i1); i1++;
            end
            q.push_back(e);
            g = ~g;
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rr_dup got extra rsp %h exp none", rsp_result);
                end else begin
                    e = q.pop_front();
                    if ({rsp_id, rsp_result, rsp_tag} !== e) begin
                        errors++;
                        $display("FAIL rr_drain got %b %h %h exp %b %h %h",
                                 rsp_id, rsp_result, rsp_tag, e.id, e.res, e.tag);
                    end
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL rr_lost got %0d pending exp 0", q.size());
        end
    endtask

    task automatic test_stall;
        do_reset();
        rsp_ready = 0;
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 4'd0; req0_tag = 4'd1;
        tick();
        req0_a = 3; req0_b = 4; req0_tag = 4'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL stall_fill got %b exp 1", req0_ready);
        end
        tick();
        req1_valid = 1; req1_a = 5; req1_b = 6; req1_op = 4'd0; req1_tag = 4'd3;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++; $display("FAIL stall_ready c=%0d got %b%b exp 00", c, req0_ready, req1_ready);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || rsp_tag !== 4'd1 || alu_a !== 32'd3) begin
                errors++;
                $display("FAIL stall_hold c=%0d got v=%b r=%h t=%h a=%h exp 1 3 1 3",
                         c, rsp_valid, rsp_result, rsp_tag, alu_a);
            end
            tick();
        end
        idle_inputs();
        rsp_ready = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || rsp_tag !== 4'd1) begin
            errors++; $display("FAIL stall_rel1 got v=%b r=%h t=%h exp 1 3 1", rsp_valid, rsp_result, rsp_tag);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_tag !== 4'd2) begin
            errors++; $display("FAIL stall_rel2 got v=%b r=%h t=%h exp 1 7 2", rsp_valid, rsp_result, rsp_tag);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_dup got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_req1_ops;
        do_reset();
        req1_valid = 1; req1_a = 32'h1; req1_b = 32'd31; req1_op = 4'd5; req1_tag = 4'd1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL r1_ready0 got %b exp 1", req1_ready);
        end
        tick();
        req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = 4'd7; req1_tag = 4'd2;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL r1_ready1 got %b exp 1", req1_ready);
        end
        tick();
        req1_a = 32'h1; req1_b = 32'hFFFF_FFFF; req1_op = 4'd9; req1_tag = 4'd3;
        #1;
        checks++;
        if (rsp_result !== 32'h8000_0000 || rsp_id !== 1'b1 || rsp_tag !== 4'd1) begin
            errors++; $display("FAIL r1_sll got %h %b %h exp 80000000 1 1", rsp_result, rsp_id, rsp_tag);
        end
        tick();
        req0_valid = 1; req0_a = 32'hF0; req0_b = 32'hFF; req0_op = 4'd4; req0_tag = 4'd5;
        req1_a = 32'd9; req1_b = 32'd9; req1_op = 4'd0; req1_tag = 4'd6;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL r1_rr got %b exp 10", {req0_ready, req1_ready});
        end
        checks++;
        if (rsp_result !== 32'hF800_0000 || rsp_tag !== 4'd2) begin
            errors++; $display("FAIL r1_sra got %h %h exp f8000000 2", rsp_result, rsp_tag);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rsp_result !== 32'h1 || rsp_id !== 1'b1 || rsp_tag !== 4'd3) begin
            errors++; $display("FAIL r1_sltu got %h %b %h exp 1 1 3", rsp_result, rsp_id, rsp_tag);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h0F || rsp_id !== 1'b0 || rsp_tag !== 4'd5) begin
            errors++;
            $display("FAIL r1_win got v=%b %h %b %h exp 1 f 0 5", rsp_valid, rsp_result, rsp_id, rsp_tag);
        end
        tick();
    endtask

    task automatic test_mid_reset;
        do_reset();
        rsp_ready = 0;
        req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 4'd0; req0_tag = 4'd4;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || alu_a !== 32'd9) begin
            errors++; $display("FAIL mrst_full got v=%b a=%h exp 1 9", rsp_valid, alu_a);
        end
        rst = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++; $display("FAIL mrst_ready got %b exp 0", req0_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || {alu_a, alu_b, alu_op} !== 68'h0) begin
            errors++;
            $display("FAIL mrst_clear got v=%b %h %h %h exp 0", rsp_valid, alu_a, alu_b, alu_op);
        end
        idle_inputs();
        rst = 0;
        rsp_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL mrst_stale c=%0d got %b exp 0", c, rsp_valid);
            end
        end
        req0_valid = 1;
        req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL mrst_ptr got %b exp 10", {req0_ready, req1_ready});
        end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_bad_op;
        do_reset();
        req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
        req1_op = 4'hF; req1_tag = 4'hA;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_id !== 1'b1 || rsp_tag !== 4'hA) begin
            errors++;
            $display("FAIL badop got v=%b %h %b %h exp 1 0 1 a", rsp_valid, rsp_result, rsp_id, rsp_tag);
        end
        tick();
    endtask

    initial begin
        rst = 1;
        rsp_ready = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_req1_ops();
        test_mid_reset();
        test_bad_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
